// File: rtl/wb_efpga_config_bridge.sv
// Wishbone-classic slave that buffers eFPGA configuration words in a FIFO and
// replays them onto the fabric self-write port with a programmable strobe gap.
module wb_efpga_config_bridge #(
  parameter int          DATA_WIDTH  = 32,
  parameter int          FIFO_DEPTH  = 16,
  parameter logic [31:0] BASE_ADDR   = 32'h3000_0000,
  parameter int          GAP_WIDTH   = 8,
  parameter int          COUNT_WIDTH = 16
) (
  input  logic                  CLK,
  input  logic                  resetn,
  input  logic                  wbs_stb_i,
  input  logic                  wbs_cyc_i,
  input  logic                  wbs_we_i,
  input  logic [3:0]            wbs_sel_i,
  input  logic [31:0]           wbs_adr_i,
  input  logic [31:0]           wbs_dat_i,
  output logic                  wbs_ack_o,
  output logic [31:0]           wbs_dat_o,
  output logic                  SelfWriteStrobe,
  output logic [DATA_WIDTH-1:0] SelfWriteData,
  output logic                  irq
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] DEPTH_L = (AW+1)'(FIFO_DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  typedef enum logic [1:0] {IDLE, STROBE, GAP} state_t;
  state_t state, state_nx;

  // Handshake: a request (cyc & stb & address match) sampled at one edge is
  // acked for exactly the next cycle; the ack itself blocks re-sampling, so a
  // master holding stb gets one access per two cycles. Side effects and read
  // data are committed at the edge that raises ack.
  logic       sel, access;
  logic [1:0] reg_idx;
  logic       wr_data, wr_status, wr_ctrl, wr_count, flush;
  logic       unused_bits;

  assign sel       = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:4] == BASE_ADDR[31:4]);
  assign access    = sel & ~wbs_ack_o;
  assign reg_idx   = wbs_adr_i[3:2];
  assign wr_data   = access & wbs_we_i & (reg_idx == 2'd0);
  assign wr_status = access & wbs_we_i & (reg_idx == 2'd1);
  assign wr_ctrl   = access & wbs_we_i & (reg_idx == 2'd2);
  assign wr_count  = access & wbs_we_i & (reg_idx == 2'd3);
  assign flush     = wr_ctrl & wbs_dat_i[1];
  assign unused_bits = ^{wbs_sel_i, wbs_adr_i[1:0]};

  logic                   ctrl_en, ctrl_irq_en;
  logic [GAP_WIDTH-1:0]   ctrl_gap, gap_cnt;
  logic [COUNT_WIDTH-1:0] count;
  logic                   ovf, done;

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW:0] wr_ptr, rd_ptr, wr_ptr_nx, rd_ptr_nx, fill, fill_nx;
  logic        empty, full, pop, push_ok, ovf_set, going_idle, done_set;

  assign fill    = wr_ptr - rd_ptr;
  assign empty   = (fill == '0);
  assign full    = (fill == DEPTH_L);
  assign push_ok = wr_data & (~full | pop);
  assign ovf_set = wr_data & full & ~pop;

  always_comb begin
    wr_ptr_nx = wr_ptr;
    rd_ptr_nx = rd_ptr;
    if (push_ok) wr_ptr_nx = wr_ptr + PTR_ONE;
    // Flush only moves the read pointer; a word already latched keeps draining.
    if (flush)    rd_ptr_nx = wr_ptr_nx;
    else if (pop) rd_ptr_nx = rd_ptr + PTR_ONE;
  end

  assign fill_nx  = wr_ptr_nx - rd_ptr_nx;
  assign done_set = going_idle & (fill_nx == '0);

  always_ff @(posedge CLK) begin
    if (push_ok) mem[wr_ptr[AW-1:0]] <= wbs_dat_i[DATA_WIDTH-1:0];
  end

  always_ff @(posedge CLK) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nx;
  end

  always_comb begin
    state_nx   = state;
    pop        = 1'b0;
    going_idle = 1'b0;
    case (state)
      IDLE: begin
        if (ctrl_en && !empty) begin
          pop      = 1'b1;
          state_nx = STROBE;
        end
      end
      STROBE: begin
        if (ctrl_gap == '0) begin
          state_nx   = IDLE;
          going_idle = 1'b1;
        end else begin
          state_nx = GAP;
        end
      end
      GAP: begin
        if (gap_cnt == GAP_WIDTH'(1)) begin
          state_nx   = IDLE;
          going_idle = 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  assign SelfWriteStrobe = (state == STROBE);

  logic [31:0] rd_mux;
  always_comb begin
    rd_mux = '0;
    case (reg_idx)
      2'd1: begin
        rd_mux[0]    = empty;
        rd_mux[1]    = full;
        rd_mux[2]    = (state != IDLE);
        rd_mux[3]    = ovf;
        rd_mux[4]    = done;
        rd_mux[15:8] = 8'(fill);
      end
      2'd2: begin
        rd_mux[0]              = ctrl_en;
        rd_mux[2]              = ctrl_irq_en;
        rd_mux[8 +: GAP_WIDTH] = ctrl_gap;
      end
      2'd3:    rd_mux[COUNT_WIDTH-1:0] = count;
      default: rd_mux = '0;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!resetn) begin
      wbs_ack_o     <= 1'b0;
      wbs_dat_o     <= '0;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      SelfWriteData <= '0;
      gap_cnt       <= '0;
      ctrl_en       <= 1'b0;
      ctrl_irq_en   <= 1'b0;
      ctrl_gap      <= '0;
      count         <= '0;
      ovf           <= 1'b0;
      done          <= 1'b0;
      irq           <= 1'b0;
    end else begin
      wbs_ack_o <= access;
      wbs_dat_o <= (access && !wbs_we_i) ? rd_mux : '0;
      wr_ptr    <= wr_ptr_nx;
      rd_ptr    <= rd_ptr_nx;
      if (pop) SelfWriteData <= mem[rd_ptr[AW-1:0]];
      if (state == STROBE)   gap_cnt <= ctrl_gap;
      else if (state == GAP) gap_cnt <= gap_cnt - GAP_WIDTH'(1);
      if (wr_ctrl) begin
        ctrl_en     <= wbs_dat_i[0];
        ctrl_irq_en <= wbs_dat_i[2];
        ctrl_gap    <= wbs_dat_i[8 +: GAP_WIDTH];
      end
      if (wr_count)                          count <= '0;
      else if (SelfWriteStrobe && count != '1) count <= count + COUNT_WIDTH'(1);
      if (ovf_set)                        ovf <= 1'b1;
      else if (wr_status && wbs_dat_i[3]) ovf <= 1'b0;
      if (done_set)                       done <= 1'b1;
      else if (wr_status && wbs_dat_i[4]) done <= 1'b0;
      irq <= ctrl_irq_en & done;
    end
  end

endmodule

// File: tb/tb_wb_efpga_config_bridge.sv
// Directed bench for wb_efpga_config_bridge: bus driver tasks feed stimulus,
// a negedge monitor scores read data and strobed words against expected queues.
module tb_wb_efpga_config_bridge;

  localparam logic [31:0] BASE    = 32'h3000_0000;
  localparam logic [31:0] A_DATA  = BASE;
  localparam logic [31:0] A_STAT  = BASE + 32'h4;
  localparam logic [31:0] A_CTRL  = BASE + 32'h8;
  localparam logic [31:0] A_COUNT = BASE + 32'hC;

  logic        CLK = 1'b0;
  logic        resetn;
  logic        wbs_stb_i, wbs_cyc_i, wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_adr_i, wbs_dat_i;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;
  logic        SelfWriteStrobe;
  logic [31:0] SelfWriteData;
  logic        irq;

  wb_efpga_config_bridge dut (
    .CLK(CLK), .resetn(resetn),
    .wbs_stb_i(wbs_stb_i), .wbs_cyc_i(wbs_cyc_i), .wbs_we_i(wbs_we_i),
    .wbs_sel_i(wbs_sel_i), .wbs_adr_i(wbs_adr_i), .wbs_dat_i(wbs_dat_i),
    .wbs_ack_o(wbs_ack_o), .wbs_dat_o(wbs_dat_o),
    .SelfWriteStrobe(SelfWriteStrobe), .SelfWriteData(SelfWriteData),
    .irq(irq)
  );

  // clock / reset
  always #5 CLK = ~CLK;
  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  // scoreboard state
  logic [31:0] exp_rd_q[$];
  logic [31:0] exp_sw_q[$];
  int          sw_cyc_q[$];
  int          sw_cnt    = 0;
  int          irq_rise  = -1;
  logic        irq_q     = 1'b0;
  int          n_cmp     = 0;
  int          n_err     = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // monitor
  always @(negedge CLK) begin
    if (resetn === 1'b1) begin
      if (wbs_ack_o && !wbs_we_i) begin
        check("rd_pending", 32'(exp_rd_q.size() > 0), 32'd1);
        if (exp_rd_q.size() > 0) check("rd_data", wbs_dat_o, exp_rd_q.pop_front());
      end
      if (SelfWriteStrobe) begin
        sw_cnt++;
        sw_cyc_q.push_back(cyc);
        check("sw_pending", 32'(exp_sw_q.size() > 0), 32'd1);
        if (exp_sw_q.size() > 0) check("sw_data", SelfWriteData, exp_sw_q.pop_front());
      end
      if (irq && !irq_q && irq_rise < 0) irq_rise = cyc;
      irq_q = irq;
    end
  end

  // driver tasks: entered and left #1 after a rising edge
  task automatic wb_access(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                           output int ack_cyc);
    wbs_cyc_i = 1'b1;
    wbs_stb_i = 1'b1;
    wbs_we_i  = we;
    wbs_adr_i = adr;
    wbs_dat_i = dat;
    ack_cyc   = -1;
    for (int i = 0; i < 8; i++) begin
      @(negedge CLK);
      if (wbs_ack_o) begin
        ack_cyc = cyc;
        break;
      end
    end
    if (ack_cyc < 0) check("ack_timeout", 32'(wbs_ack_o), 32'd1);
    @(posedge CLK); #1;
    wbs_cyc_i = 1'b0;
    wbs_stb_i = 1'b0;
    wbs_we_i  = 1'b0;
  endtask

  task automatic wb_write(input logic [31:0] adr, input logic [31:0] dat);
    int d;
    wb_access(1'b1, adr, dat, d);
  endtask

  task automatic wb_read(input logic [31:0] adr, input logic [31:0] exp);
    int d;
    exp_rd_q.push_back(exp);
    wb_access(1'b0, adr, 32'h0, d);
  endtask

  task automatic push_word(input logic [31:0] w, input bit strobed);
    if (strobed) exp_sw_q.push_back(w);
    wb_write(A_DATA, w);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  initial begin
    #200000;
    n_err++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    int ack_c, base_cnt, acks;
    resetn    = 1'b0;
    wbs_cyc_i = 1'b0;
    wbs_stb_i = 1'b0;
    wbs_we_i  = 1'b0;
    wbs_sel_i = 4'hF;
    wbs_adr_i = '0;
    wbs_dat_i = '0;

    // reset
    repeat (3) @(posedge CLK);
    #1;
    check("rst_ack", 32'(wbs_ack_o), 32'd0);
    check("rst_dat", wbs_dat_o, 32'd0);
    check("rst_strobe", 32'(SelfWriteStrobe), 32'd0);
    check("rst_swdata", SelfWriteData, 32'd0);
    check("rst_irq", 32'(irq), 32'd0);
    resetn = 1'b1;
    idle(1);
    wb_read(A_STAT, 32'h0000_0001);

    // single word, gap 0
    wb_write(A_CTRL, 32'h0000_0001);
    wb_read(A_CTRL, 32'h0000_0001);
    sw_cyc_q.delete();
    exp_sw_q.push_back(32'hDEAD_BEEF);
    wb_access(1'b1, A_DATA, 32'hDEAD_BEEF, ack_c);
    @(negedge CLK);
    check("ack_one_cycle", 32'(wbs_ack_o), 32'd0);
    @(posedge CLK); #1;
    idle(3);
    check("single_strobes", 32'(sw_cyc_q.size()), 32'd1);
    if (sw_cyc_q.size() == 1) check("single_latency", 32'(sw_cyc_q[0]), 32'(ack_c + 1));
    wb_read(A_COUNT, 32'h0000_0001);
    wb_read(A_STAT, 32'h0000_0011);

    // pacing, gap 3
    wb_write(A_COUNT, 32'h0);
    wb_write(A_STAT, 32'h10);
    wb_write(A_CTRL, 32'h0000_0301);
    sw_cyc_q.delete();
    push_word(32'h1111_1111, 1'b1);
    push_word(32'h2222_2222, 1'b1);
    push_word(32'h3333_3333, 1'b1);
    push_word(32'h4444_4444, 1'b1);
    idle(30);
    check("pace_strobes", 32'(sw_cyc_q.size()), 32'd4);
    if (sw_cyc_q.size() == 4)
      for (int i = 1; i < 4; i++) check("pace_period", 32'(sw_cyc_q[i] - sw_cyc_q[i-1]), 32'd5);
    wb_read(A_COUNT, 32'h0000_0004);
    wb_read(A_STAT, 32'h0000_0011);

    // overflow with EN=0, then drain
    wb_write(A_CTRL, 32'h0);
    wb_write(A_STAT, 32'h18);
    wb_write(A_COUNT, 32'h0);
    for (int i = 0; i < 18; i++) push_word(32'h0000_0100 + 32'(i), i < 16);
    wb_read(A_STAT, 32'h0000_100A);
    base_cnt = sw_cnt;
    wb_write(A_CTRL, 32'h0000_0001);
    idle(45);
    check("ovf_drain_strobes", 32'(sw_cnt - base_cnt), 32'd16);
    wb_read(A_COUNT, 32'h0000_0010);
    wb_write(A_STAT, 32'h08);
    wb_read(A_STAT, 32'h0000_0011);

    // EN cleared during the first gap, then flush
    wb_write(A_CTRL, 32'h0000_0A00);
    wb_write(A_STAT, 32'h10);
    wb_write(A_COUNT, 32'h0);
    for (int i = 0; i < 5; i++) push_word(32'hC0DE_0000 + 32'(i), i == 0);
    base_cnt = sw_cnt;
    wb_write(A_CTRL, 32'h0000_0A01);
    wb_write(A_CTRL, 32'h0000_0A00);
    idle(20);
    check("en_clear_strobes", 32'(sw_cnt - base_cnt), 32'd1);
    wb_read(A_STAT, 32'h0000_0400);
    wb_write(A_CTRL, 32'h0000_0A02);
    wb_read(A_STAT, 32'h0000_0001);
    wb_read(A_CTRL, 32'h0000_0A00);
    wb_write(A_CTRL, 32'h0000_0A01);
    idle(20);
    check("flush_strobes", 32'(sw_cnt - base_cnt), 32'd1);
    wb_read(A_STAT, 32'h0000_0001);
    wb_read(A_COUNT, 32'h0000_0001);

    // interrupt
    wb_write(A_CTRL, 32'h0000_0005);
    check("irq_idle", 32'(irq), 32'd0);
    irq_rise = -1;
    sw_cyc_q.delete();
    push_word(32'hAAAA_5555, 1'b1);
    push_word(32'h5555_AAAA, 1'b1);
    idle(10);
    check("irq_strobes", 32'(sw_cyc_q.size()), 32'd2);
    if (sw_cyc_q.size() == 2) begin
      check("irq_spacing", 32'(sw_cyc_q[1] - sw_cyc_q[0]), 32'd2);
      check("irq_rise", 32'(irq_rise), 32'(sw_cyc_q[1] + 2));
    end
    check("irq_high", 32'(irq), 32'd1);
    wb_read(A_STAT, 32'h0000_0011);
    wb_write(A_STAT, 32'h10);
    idle(2);
    check("irq_cleared", 32'(irq), 32'd0);
    wb_read(A_STAT, 32'h0000_0001);

    // address decode
    acks = 0;
    wbs_cyc_i = 1'b1;
    wbs_stb_i = 1'b1;
    wbs_we_i  = 1'b0;
    wbs_adr_i = BASE + 32'h10;
    for (int i = 0; i < 8; i++) begin
      @(negedge CLK);
      if (wbs_ack_o) acks++;
    end
    check("unsel_acks", 32'(acks), 32'd0);
    @(posedge CLK); #1;
    wbs_cyc_i = 1'b0;
    wbs_stb_i = 1'b0;
    idle(2);

    check("rd_queue_empty", 32'(exp_rd_q.size()), 32'd0);
    check("sw_queue_empty", 32'(exp_sw_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
